// File: rtl/usb_buffer_arbiter_pkg.sv
// Shared definitions for the USB packet-buffer arbiter: address map constants,
// requester identifiers and the read-tag layout.
package usb_buffer_arbiter_pkg;

  localparam logic [31:0] ADDRESS_USB_PACKET_BUFFER = 32'h4000_6000;
  localparam int unsigned USB_PACKET_BUFFER_SIZE    = 32'd1024;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_USB = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } read_tag_t;

  function automatic logic is_read(input logic [3:0] wstrb);
    return (wstrb == 4'b0000);
  endfunction

endpackage

// File: rtl/usb_buffer_starve_counter.sv
// Counts consecutive USB wins while the CPU waits and forces a CPU grant
// once that run reaches STARVE_LIMIT.
module usb_buffer_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk48,
  input  logic reset,
  input  logic cpu_req,
  input  logic usb_req,
  output logic force_cpu
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             force_s;

  // Force decision and next count; a CPU win of any kind restarts the run
  always_comb begin
    force_s     = 1'b0;
    count_nxt_s = count_r;
    if (!cpu_req) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (count_r >= LIMIT_C) begin
      force_s     = 1'b1;
      count_nxt_s = {CNT_W{1'b0}};
    end else if (usb_req) begin
      count_nxt_s = count_r + ONE_C;
    end else begin
      count_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Counter register
  always_ff @(posedge clk48) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign force_cpu = force_s;

endmodule

// File: rtl/usb_buffer_arbiter.sv
// Two-port arbiter in front of the USB packet-buffer RAM: USB has priority,
// the CPU is guaranteed a slot after STARVE_LIMIT lost cycles.
module usb_buffer_arbiter
  import usb_buffer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk48,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic [3:0]            cpu_wstrb,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  usb_req,
  input  logic [ADDR_WIDTH-1:0] usb_addr,
  input  logic [DATA_WIDTH-1:0] usb_wdata,
  input  logic [3:0]            usb_wstrb,
  output logic                  usb_gnt,
  output logic                  usb_rvalid,
  output logic [DATA_WIDTH-1:0] usb_rdata,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [3:0]            ram_wstrb,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  starved
);

  logic      force_cpu_s;
  logic      cpu_win_s;
  logic      usb_win_s;
  read_tag_t tag_r;
  read_tag_t tag_nxt_s;

  usb_buffer_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk48     (clk48),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .usb_req   (usb_req),
    .force_cpu (force_cpu_s)
  );

  // Grant selection; nothing is granted while reset is held
  always_comb begin
    cpu_win_s = 1'b0;
    usb_win_s = 1'b0;
    if (reset) begin
      cpu_win_s = 1'b0;
      usb_win_s = 1'b0;
    end else if (cpu_req && (force_cpu_s || !usb_req)) begin
      cpu_win_s = 1'b1;
    end else if (usb_req) begin
      usb_win_s = 1'b1;
    end else begin
      cpu_win_s = 1'b0;
      usb_win_s = 1'b0;
    end
  end

  // RAM port mux driven by the winner
  always_comb begin
    ram_en    = 1'b0;
    ram_addr  = {ADDR_WIDTH{1'b0}};
    ram_wdata = {DATA_WIDTH{1'b0}};
    ram_wstrb = 4'b0000;
    if (cpu_win_s) begin
      ram_en    = 1'b1;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_wstrb = cpu_wstrb;
    end else if (usb_win_s) begin
      ram_en    = 1'b1;
      ram_addr  = usb_addr;
      ram_wdata = usb_wdata;
      ram_wstrb = usb_wstrb;
    end else begin
      ram_en    = 1'b0;
      ram_wstrb = 4'b0000;
    end
  end

  // Tag for the read whose data returns next cycle
  always_comb begin
    tag_nxt_s.valid = ram_en & is_read(ram_wstrb);
    tag_nxt_s.owner = usb_win_s ? OWNER_USB : OWNER_CPU;
  end

  // Read-tag register
  always_ff @(posedge clk48) begin
    if (reset) begin
      tag_r <= '{valid: 1'b0, owner: OWNER_CPU};
    end else begin
      tag_r <= tag_nxt_s;
    end
  end

  assign cpu_gnt    = cpu_win_s;
  assign usb_gnt    = usb_win_s;
  assign starved    = force_cpu_s & ~reset;
  // Gating with reset keeps a read granted just before reset from surfacing
  assign cpu_rvalid = tag_r.valid & (tag_r.owner == OWNER_CPU) & ~reset;
  assign usb_rvalid = tag_r.valid & (tag_r.owner == OWNER_USB) & ~reset;
  assign cpu_rdata  = ram_rdata;
  assign usb_rdata  = ram_rdata;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Scoreboard bench for usb_buffer_arbiter: directed scenarios then random
// traffic against a reference model of grants, starvation and buffer contents.
module tb_usb_buffer_arbiter;
  import usb_buffer_arbiter_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  logic          reset     = 1'b1;
  logic          cpu_req   = 1'b0;
  logic [AW-1:0] cpu_addr  = 8'h00;
  logic [DW-1:0] cpu_wdata = 32'h0;
  logic [3:0]    cpu_wstrb = 4'h0;
  logic          usb_req   = 1'b0;
  logic [AW-1:0] usb_addr  = 8'h00;
  logic [DW-1:0] usb_wdata = 32'h0;
  logic [3:0]    usb_wstrb = 4'h0;
  logic [DW-1:0] ram_rdata = 32'h0;
  logic          cpu_gnt, cpu_rvalid, usb_gnt, usb_rvalid, ram_en, starved;
  logic [DW-1:0] cpu_rdata, usb_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wstrb;

  usb_buffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk48(clk48), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .usb_req(usb_req), .usb_addr(usb_addr), .usb_wdata(usb_wdata), .usb_wstrb(usb_wstrb),
    .usb_gnt(usb_gnt), .usb_rvalid(usb_rvalid), .usb_rdata(usb_rdata),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_rdata(ram_rdata), .starved(starved)
  );

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Environment RAM outside the DUT: one-cycle read latency, byte-enabled writes
  logic [31:0] mem [256];
  bit          wr_seen [256] = '{default: 1'b0};
  function automatic logic [31:0] rd_env(input logic [7:0] a);
    return wr_seen[a] ? mem[a] : init_word(a);
  endfunction
  always @(posedge clk48) begin
    if (ram_en) begin
      if (ram_wstrb != 4'b0000) begin
        mem[ram_addr]     <= merge(rd_env(ram_addr), ram_wdata, ram_wstrb);
        wr_seen[ram_addr] <= 1'b1;
      end else begin
        ram_rdata <= rd_env(ram_addr);
      end
    end
  end

  // Reference model state
  typedef struct { logic owner; logic [31:0] data; int due; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          checks = 0, failures = 0, cyc = 0, w = 0;

  always @(posedge clk48) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Staged stimulus, applied at the next falling edge
  logic          s_rst = 1'b1, s_creq = 1'b0, s_ureq = 1'b0;
  logic [AW-1:0] s_caddr = 8'h00, s_uaddr = 8'h00;
  logic [DW-1:0] s_cwdata = 32'h0, s_uwdata = 32'h0;
  logic [3:0]    s_cwstrb = 4'h0, s_uwstrb = 4'h0;
  bit            keep_u = 1'b0, rand_mode = 1'b0;
  logic          l_cg, l_ug, l_st, l_ren, l_crv, l_urv;
  logic [3:0]    l_rws;
  logic [31:0]   l_crd, l_urd;

  task automatic new_cpu();
    s_creq   = ($urandom_range(0, 2) != 0);
    s_caddr  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
    s_cwdata = $urandom;
    s_cwstrb = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
  endtask

  task automatic new_usb();
    s_ureq   = ($urandom_range(0, 7) != 0);
    s_uaddr  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
    s_uwdata = $urandom;
    s_uwstrb = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
  endtask

  task automatic step();
    logic exp_cg, exp_ug, exp_st;
    @(negedge clk48);
    reset = s_rst; cpu_req = s_creq; cpu_addr = s_caddr; cpu_wdata = s_cwdata; cpu_wstrb = s_cwstrb;
    usb_req = s_ureq; usb_addr = s_uaddr; usb_wdata = s_uwdata; usb_wstrb = s_uwstrb;
    if (s_rst) exp_q.delete();
    #2;
    exp_cg = !reset && cpu_req && (!usb_req || w == LIMIT);
    exp_ug = !reset && usb_req && !exp_cg;
    exp_st = !reset && cpu_req && (w == LIMIT);
    chk("cpu_gnt", 64'(cpu_gnt), 64'(exp_cg));
    chk("usb_gnt", 64'(usb_gnt), 64'(exp_ug));
    chk("starved", 64'(starved), 64'(exp_st));
    chk("ram_en", 64'(ram_en), 64'(exp_cg || exp_ug));
    if (exp_cg)
      chk("ram_bus_cpu", 64'({ram_addr, ram_wstrb, ram_wdata}), 64'({cpu_addr, cpu_wstrb, cpu_wdata}));
    else if (exp_ug)
      chk("ram_bus_usb", 64'({ram_addr, ram_wstrb, ram_wdata}), 64'({usb_addr, usb_wstrb, usb_wdata}));
    else
      chk("ram_idle_wstrb", 64'(ram_wstrb), 64'd0);
    if (reset) chk("reset_rvalid", 64'({cpu_rvalid, usb_rvalid}), 64'd0);
    l_cg = cpu_gnt; l_ug = usb_gnt; l_st = starved; l_ren = ram_en; l_rws = ram_wstrb;
    l_crv = cpu_rvalid; l_urv = usb_rvalid; l_crd = cpu_rdata; l_urd = usb_rdata;
    if (exp_cg) begin
      if (cpu_wstrb == 4'h0) exp_q.push_back('{owner: 1'b0, data: ref_mem[cpu_addr], due: cyc + 1});
      else ref_mem[cpu_addr] = merge(ref_mem[cpu_addr], cpu_wdata, cpu_wstrb);
    end
    if (exp_ug) begin
      if (usb_wstrb == 4'h0) exp_q.push_back('{owner: 1'b1, data: ref_mem[usb_addr], due: cyc + 1});
      else ref_mem[usb_addr] = merge(ref_mem[usb_addr], usb_wdata, usb_wstrb);
    end
    if (reset || !cpu_req || exp_cg) w = 0;
    else if (w < LIMIT) w = w + 1;
    else w = LIMIT;
    if (rand_mode) begin
      if (exp_cg || !s_creq) new_cpu();
      if (exp_ug || !s_ureq) new_usb();
      s_rst = ($urandom_range(0, 59) == 0);
    end else begin
      if (exp_cg) s_creq = 1'b0;
      if (exp_ug && !keep_u) s_ureq = 1'b0;
    end
  endtask

  // Monitor: read responses must match the scoreboard, one cycle after grant
  initial begin
    exp_t e;
    forever begin
      @(negedge clk48);
      #1;
      chk("rvalid_exclusive", 64'(cpu_rvalid & usb_rvalid), 64'd0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        if (e.owner) chk("usb_read", 64'({usb_rvalid, cpu_rvalid, usb_rdata}), 64'({1'b1, 1'b0, e.data}));
        else         chk("cpu_read", 64'({cpu_rvalid, usb_rvalid, cpu_rdata}), 64'({1'b1, 1'b0, e.data}));
      end else begin
        chk("no_spurious_rvalid", 64'({cpu_rvalid, usb_rvalid}), 64'd0);
      end
    end
  end

  initial begin
    logic [8:0]  ug_h, cg_h, st_h;
    logic [31:0] tmpw;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    step(); step();
    s_rst = 1'b0;

    // CPU-only read
    s_creq = 1'b1; s_caddr = 8'h10; s_cwstrb = 4'h0;
    step(); chk("cpu_only_gnt", 64'({l_cg, l_ug}), 64'(2'b10));
    step(); chk("cpu_only_rdata", 64'({l_crv, l_urv, l_crd}), 64'({1'b1, 1'b0, init_word(8'h10)}));

    // Simultaneous requests: four USB wins, forced CPU, then USB again
    s_creq = 1'b1; s_caddr = 8'h20; s_cwstrb = 4'h0;
    s_ureq = 1'b1; s_uaddr = 8'h30; s_uwstrb = 4'h0; keep_u = 1'b1;
    ug_h = 9'h0; cg_h = 9'h0; st_h = 9'h0;
    for (int i = 0; i < 6; i++) begin
      step(); ug_h[i] = l_ug; cg_h[i] = l_cg; st_h[i] = l_st;
    end
    chk("starve_usb_pattern", 64'(ug_h[5:0]), 64'(6'b101111));
    chk("starve_cpu_pattern", 64'({cg_h[5:0], st_h[5:0]}), 64'({6'b010000, 6'b010000}));
    keep_u = 1'b0; s_ureq = 1'b0; step();

    // Partial USB write then CPU read of the same word
    s_ureq = 1'b1; s_uaddr = 8'h05; s_uwdata = 32'hAABBCCDD; s_uwstrb = 4'b0011;
    step(); chk("partial_wr_strb", 64'({l_ug, l_rws}), 64'({1'b1, 4'b0011}));
    s_creq = 1'b1; s_caddr = 8'h05; s_cwstrb = 4'h0;
    step(); step();
    tmpw = init_word(8'h05);
    chk("partial_rd_data", 64'({l_crv, l_crd}), 64'({1'b1, tmpw[31:16], 16'hCCDD}));

    // Interleaved reads
    s_ureq = 1'b1; s_uaddr = 8'h01; s_uwstrb = 4'h0;
    step();
    s_creq = 1'b1; s_caddr = 8'h02; s_cwstrb = 4'h0;
    step(); chk("interleave_usb", 64'({l_urv, l_crv, l_urd}), 64'({1'b1, 1'b0, init_word(8'h01)}));
    step(); chk("interleave_cpu", 64'({l_crv, l_urv, l_crd}), 64'({1'b1, 1'b0, init_word(8'h02)}));

    // Reset arriving right after a granted read
    s_creq = 1'b1; s_caddr = 8'h40; s_cwstrb = 4'h0;
    step(); chk("pre_reset_gnt", 64'(l_cg), 64'd1);
    s_rst = 1'b1; step();
    chk("reset_outputs", 64'({l_cg, l_ug, l_st, l_ren, l_rws, l_crv, l_urv}), 64'd0);
    s_rst = 1'b0; step(); chk("no_rvalid_after_reset", 64'({l_crv, l_urv}), 64'd0);

    // Counter restart after the CPU drops its request
    s_creq = 1'b1; s_caddr = 8'h50; s_cwstrb = 4'h0;
    s_ureq = 1'b1; s_uaddr = 8'h60; s_uwstrb = 4'h0; keep_u = 1'b1;
    ug_h = 9'h0; cg_h = 9'h0; st_h = 9'h0;
    for (int i = 0; i < 9; i++) begin
      s_creq = (i != 3);
      step(); ug_h[i] = l_ug; cg_h[i] = l_cg; st_h[i] = l_st;
    end
    chk("restart_usb_pattern", 64'(ug_h), 64'(9'b011111111));
    chk("restart_cpu_pattern", 64'({cg_h, st_h}), 64'({9'b100000000, 9'b100000000}));
    keep_u = 1'b0; s_ureq = 1'b0; s_creq = 1'b0; step();

    // Random traffic with occasional resets
    rand_mode = 1'b1;
    new_cpu(); new_usb();
    repeat (600) step();
    rand_mode = 1'b0; s_rst = 1'b0; s_creq = 1'b0; s_ureq = 1'b0;
    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
